// File: rtl/adc_scan_ctrl.sv
// Round-robin scan controller for an ADC083x-style serial ADC, with a registered
// bus slave exposing per-channel results, control, status and a frame counter.
module adc_scan_ctrl #(
    parameter int NCH     = 4,
    parameter int RES     = 8,
    parameter int MUX_W   = 3,
    parameter int CLK_DIV = 512,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bus_cs_n,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic              adc_din,
    input  logic              adc_dout,
    input  logic              adc_sars
);
    localparam int CMD_N = 2 + MUX_W;
    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_state;
    logic [2:0]       r_ch;
    logic             r_idle_cnt;
    logic [4:0]       r_bit;
    logic [RES-1:0]   r_shreg;
    logic [RES-1:0]   r_result [NCH];
    logic [NCH-1:0]   r_new;
    logic             r_en;
    logic [NCH-1:0]   r_mask;
    logic [15:0]      r_scancnt;
    logic             r_sars_meta;
    logic             r_sars_sync;
    logic [15:0]      r_readdata;
    logic             r_cs_n;
    logic             r_sclk;
    logic             r_din;

    logic        w_tick;
    logic        w_go;
    logic        w_done;
    logic        w_rd;
    logic        w_wr;
    logic [2:0]  w_next_ch;
    logic [7:0]  w_mask8;
    logic [15:0] w_ch_val;
    logic [15:0] w_ctrl_val;
    logic [15:0] w_rd_val;
    logic        w_unused;

    // Mux field carries the channel index LSB first, i.e. left-aligned in the field.
    function automatic logic cmd_bit(input logic [2:0] ch, input logic [4:0] idx);
        logic [4:0] k;
        logic       b;
        k = idx - 5'd2;
        if (idx < 5'd2) begin
            b = 1'b1;
        end else begin
            case (k)
                5'd0:    b = ch[0];
                5'd1:    b = ch[1];
                5'd2:    b = ch[2];
                default: b = 1'b0;
            endcase
        end
        return b;
    endfunction

    assign w_tick   = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_go     = r_en && (r_mask != {NCH{1'b0}});
    assign w_done   = (r_state == S_DONE);
    assign w_rd     = !bus_cs_n && !read_n;
    assign w_wr     = !bus_cs_n && !write_n;
    assign w_mask8  = 8'(r_mask);
    assign w_unused = ^writedata[14:NCH];

    assign readdata = r_readdata;
    assign adc_cs_n = r_cs_n;
    assign adc_sclk = r_sclk;
    assign adc_din  = r_din;

    // Tick divider: one tick per CLK_DIV clk cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= {DIV_W{1'b0}};
        end else if (w_tick) begin
            r_div <= {DIV_W{1'b0}};
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Next channel: lowest enabled index above the last one, wrapping (smallest step wins).
    always_comb begin
        logic [3:0] v_idx;
        w_next_ch = r_ch;
        v_idx     = 4'd0;
        for (int i = NCH; i >= 1; i--) begin
            v_idx     = {1'b0, r_ch} + 4'(i);
            v_idx     = (v_idx >= 4'(NCH)) ? (v_idx - 4'(NCH)) : v_idx;
            w_next_ch = w_mask8[v_idx[2:0]] ? v_idx[2:0] : w_next_ch;
        end
    end

    // Frame sequencer; pins move only on tick, DONE is a single clk cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ch       <= 3'd0;
            r_idle_cnt <= 1'b0;
            r_bit      <= 5'd0;
            r_shreg    <= {RES{1'b0}};
            r_cs_n     <= 1'b1;
            r_sclk     <= 1'b0;
            r_din      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_tick) begin
                    if (!r_idle_cnt) begin
                        r_idle_cnt <= 1'b1;
                    end else if (w_go) begin
                        r_ch    <= w_next_ch;
                        r_cs_n  <= 1'b0;
                        r_din   <= 1'b1;
                        r_bit   <= 5'd0;
                        r_state <= S_CMD;
                    end
                end
                S_CMD: if (w_tick) begin
                    if (!r_sclk) begin
                        r_sclk <= 1'b1;
                    end else begin
                        r_sclk <= 1'b0;
                        if (r_bit == 5'(CMD_N - 1)) begin
                            r_din   <= 1'b0;
                            r_state <= S_SETTLE;
                        end else begin
                            r_bit <= r_bit + 5'd1;
                            r_din <= cmd_bit(r_ch, r_bit + 5'd1);
                        end
                    end
                end
                S_SETTLE: if (w_tick) begin
                    if (!r_sclk) begin
                        r_sclk <= 1'b1;
                    end else begin
                        r_sclk  <= 1'b0;
                        r_bit   <= 5'd0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: if (w_tick) begin
                    if (!r_sclk) begin
                        r_sclk  <= 1'b1;
                        r_shreg <= RES'({r_shreg, adc_dout});
                    end else begin
                        r_sclk <= 1'b0;
                        if (r_bit == 5'(RES - 1)) begin
                            r_cs_n  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_bit <= r_bit + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_idle_cnt <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_idle_cnt <= 1'b0;
                    r_cs_n     <= 1'b1;
                    r_sclk     <= 1'b0;
                    r_din      <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Result store; a completing frame sets NEW even when a read clears it in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_result[i] <= {RES{1'b0}};
            end
            r_new     <= {NCH{1'b0}};
            r_scancnt <= 16'd0;
        end else begin
            if (w_done) begin
                r_scancnt <= r_scancnt + 16'd1;
            end
            for (int i = 0; i < NCH; i++) begin
                if (w_done && (r_ch == 3'(i))) begin
                    r_result[i] <= r_shreg;
                    r_new[i]    <= 1'b1;
                end else if (w_rd && (addr == ADDR_W'(i))) begin
                    r_new[i] <= 1'b0;
                end
            end
        end
    end

    // Control register, SARS synchroniser and registered read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en        <= 1'b0;
            r_mask      <= {NCH{1'b0}};
            r_sars_meta <= 1'b0;
            r_sars_sync <= 1'b0;
            r_readdata  <= 16'd0;
        end else begin
            r_sars_meta <= adc_sars;
            r_sars_sync <= r_sars_meta;
            if (w_wr && (addr == ADDR_W'(NCH))) begin
                r_en   <= writedata[15];
                r_mask <= writedata[NCH-1:0];
            end
            if (w_rd) begin
                r_readdata <= w_rd_val;
            end
        end
    end

    // Read mux built from pre-update register values.
    always_comb begin
        logic [15:0] v_ch;
        w_ch_val = 16'd0;
        v_ch     = 16'd0;
        for (int i = 0; i < NCH; i++) begin
            v_ch           = 16'd0;
            v_ch[15]       = r_new[i];
            v_ch[RES-1:0]  = r_result[i];
            w_ch_val       = (addr == ADDR_W'(i)) ? v_ch : w_ch_val;
        end
        w_ctrl_val          = 16'd0;
        w_ctrl_val[15]      = r_en;
        w_ctrl_val[NCH-1:0] = r_mask;
        case (addr)
            ADDR_W'(NCH):     w_rd_val = w_ctrl_val;
            ADDR_W'(NCH + 1): w_rd_val = {(r_state != S_IDLE), r_sars_sync, 11'd0, r_ch};
            ADDR_W'(NCH + 2): w_rd_val = r_scancnt;
            default:          w_rd_val = w_ch_val;
        endcase
    end
endmodule
